// File: rtl/datapath_step_sequencer_pkg.sv
// rtl/datapath_step_sequencer_pkg.sv - shared states, opcodes and bus-select indices
package datapath_step_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_DONE
    } step_state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    // out_sel bit positions above the sixteen general registers
    localparam int SEL_HI     = 16;
    localparam int SEL_LO     = 17;
    localparam int SEL_ZHIGH  = 18;
    localparam int SEL_ZLOW   = 19;
    localparam int SEL_PC     = 20;
    localparam int SEL_MDR    = 21;
    localparam int SEL_INPORT = 22;
    localparam int SEL_C      = 23;

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || is_muldiv_op(op);
    endfunction

endpackage

// File: rtl/datapath_step_sequencer_step_wait_counter.sv
// rtl/datapath_step_sequencer_step_wait_counter.sv - T1 memory-wait timeout counter
module step_wait_counter #(
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    input  logic restart,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] count;

    // count holds the number of completed unready T1 cycles, so the flag
    // is raised during the WAIT_MAX-th T1 cycle
    assign timeout = (count == CW'(WAIT_MAX - 1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/datapath_step_sequencer.sv
// rtl/datapath_step_sequencer.sv - fetch/execute control-step sequencer for the bus datapath
module datapath_step_sequencer
    import datapath_step_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [23:0] out_sel,
    output logic [15:0] rin,
    output logic        pc_in,
    output logic        ir_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        read,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        err
);

    step_state_t state, state_next;
    logic        cnt_enable;
    logic        cnt_restart;
    logic        wait_timeout;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];

    step_wait_counter #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clock   (clock),
        .clear   (clear),
        .enable  (cnt_enable),
        .restart (cnt_restart),
        .timeout (wait_timeout)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        out_sel     = '0;
        rin         = '0;
        pc_in       = 1'b0;
        ir_in       = 1'b0;
        mar_in      = 1'b0;
        mdr_in      = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        read        = 1'b0;
        inc_pc      = 1'b0;
        alu_op      = '0;
        busy        = (state != ST_IDLE);
        done        = 1'b0;
        err         = 1'b0;
        cnt_enable  = 1'b0;
        cnt_restart = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_T0;
                end
            end
            ST_T0: begin
                out_sel[SEL_PC] = 1'b1;
                mar_in          = 1'b1;
                inc_pc          = 1'b1;
                z_in            = 1'b1;
                cnt_restart     = 1'b1;
                state_next      = ST_T1;
            end
            ST_T1: begin
                out_sel[SEL_ZLOW] = 1'b1;
                pc_in             = 1'b1;
                read              = 1'b1;
                // the only Mealy output: capture read data the cycle it is valid
                mdr_in            = mem_ready;
                if (mem_ready) begin
                    state_next = ST_T2;
                end else if (wait_timeout) begin
                    err        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ST_T2: begin
                out_sel[SEL_MDR] = 1'b1;
                ir_in            = 1'b1;
                state_next       = ST_T3;
            end
            ST_T3: begin
                if (is_legal_op(opcode)) begin
                    out_sel    = 24'(1) << rb;
                    y_in       = 1'b1;
                    state_next = ST_T4;
                end else begin
                    err        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_T4: begin
                out_sel    = 24'(1) << rc;
                z_in       = 1'b1;
                alu_op     = opcode;
                state_next = ST_T5;
            end
            ST_T5: begin
                out_sel[SEL_ZLOW] = 1'b1;
                if (is_muldiv_op(opcode)) begin
                    lo_in      = 1'b1;
                    state_next = ST_T6;
                end else begin
                    rin        = 16'(1) << ra;
                    state_next = ST_DONE;
                end
            end
            ST_T6: begin
                out_sel[SEL_ZHIGH] = 1'b1;
                hi_in              = 1'b1;
                state_next         = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
